// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the ROM address, buffers one fetched word for decode.
// Optional FETCH_PERF_EN adds saturating handshake/stall counters.
//
// state | meaning
// IDLE  | first cycle after reset, nothing captured
// RUN   | fetching, one word per free slot
// DRAIN | LAST_ADDR fetched, waiting for decode to take it
// HALT  | terminal until rst
module fetch_ctrl #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(8'h00),
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(8'h48)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] addy,
  input  logic [31:0]       inst_in,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic              err
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              slot_free;
  logic              redirect_bad;

  assign addy         = pc;
  assign slot_free    = !out_valid || out_ready;
  assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= NOP;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_RUN;
        S_RUN, S_DRAIN: begin
          // a redirect flushes the slot even if decode is taking it this cycle
          if (redirect) begin
            out_valid <= 1'b0;
            if (redirect_bad) begin
              err    <= 1'b1;
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              pc    <= redirect_pc;
              state <= S_RUN;
            end
          end else if (state == S_RUN) begin
            if (slot_free) begin
              out_inst  <= inst_in;
              out_pc    <= pc;
              out_valid <= 1'b1;
              if (pc == LAST_ADDR) state <= S_DRAIN;
              else                 pc    <= pc + ADDR_W'(4);
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            halted    <= 1'b1;
            state     <= S_HALT;
          end
        end
        S_HALT:  out_valid <= 1'b0;
        default: state <= S_HALT;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && out_ready && fetch_cnt != 16'hFFFF)  fetch_cnt <= fetch_cnt + 16'd1;
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
